// File: rtl/div_seq_32.sv
// Sequential unsigned 32-bit restoring divider: one trial subtraction per clock
// through a ripple full_sub_32, valid/ready handshakes on operands and results.

module full_sub_1 (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

module full_sub_32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        bin,
  output logic [31:0] d,
  output logic        bout
);
  logic [32:0] b;
  assign b[0] = bin;
  assign bout = b[32];

  for (genvar i = 0; i < 32; i++) begin : g_bit
    full_sub_1 u_fs (.x(x[i]), .y(y[i]), .bin(b[i]), .d(d[i]), .bout(b[i+1]));
  end
endmodule

module div_seq_32 #(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] DIV0_Q = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] dvsr, rem, q;
  logic [4:0]       cnt;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] d;
  logic             bout, take;
  logic [WIDTH-1:0] rem_nxt, q_nxt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign shifted = {rem, q[WIDTH-1]};

  full_sub_32 u_sub (.x(shifted[WIDTH-1:0]), .y(dvsr), .bin(1'b0), .d(d), .bout(bout));

  // A set bit 32 means the partial remainder already exceeds any 32-bit divisor;
  // the low 32 bits of the difference are still exact in that case.
  assign take    = shifted[WIDTH] | ~bout;
  assign rem_nxt = take ? d : shifted[WIDTH-1:0];
  assign q_nxt   = {q[WIDTH-2:0], take};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      dvsr        <= '0;
      rem         <= '0;
      q           <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (divisor == '0) begin
            quotient    <= DIV0_Q;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
            state       <= DONE;
          end else begin
            dvsr  <= divisor;
            rem   <= '0;
            q     <= dividend;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          rem <= rem_nxt;
          q   <= q_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            quotient    <= q_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
